// File: rtl/gtx_tx_frame_arbiter.sv
// Round-robin arbiter and link framer for the shared 16-bit GTX TX lane.
// Each granted transfer goes out as:
//   header 0x2410, 0x1984, opcode, payload[0..L-1], checksum, tail 0xDBEF, 0xE67B
// K-idle 0x02BC (TXCTRL = 01) is sent between frames. After a tail, exactly
// IDLE_GAP K words go out before the next header when requests are pending.
//
// Source handshake: src_rd[i] is a one-cycle strobe. src_data slice i must be
// valid in every cycle where src_rd[i] is high. The word is captured at the end
// of that cycle. The source presents its next word in the following cycle.
// A source whose gnt bit falls without a frm_done pulse must flush its frame.
module gtx_tx_frame_arbiter #(
  parameter int N        = 3,
  parameter int IDLE_GAP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_en,
  input  logic [N-1:0]      req,
  input  logic [16*N-1:0]   opcode,
  input  logic [8*N-1:0]    len,
  input  logic [16*N-1:0]   src_data,
  output logic [N-1:0]      src_rd,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      frm_done,
  output logic [15:0]       TX_DATA,
  output logic [1:0]        TXCTRL,
  output logic              busy,
  output logic [15:0]       frm_cnt,
  output logic [2:0]        dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] K_IDLE = 16'h02BC;

  // Each state names the word that TX_DATA is currently presenting.
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_OPC, S_PAY, S_CSUM, S_TAIL0, S_TAIL1
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    tx_q, tx_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   src_rd_q, src_rd_d;
  logic [N-1:0]   done_q, done_d;
  logic           busy_q, busy_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [3:0]     gap_q, gap_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  win_q, win_d;
  logic [15:0]    opc_q, opc_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     rem_q, rem_d;
  logic [15:0]    csum_q, csum_d;

  logic           found;
  logic [PW-1:0]  win_sel;
  logic           gap_ok;
  logic [15:0]    src_word;

  // Round-robin search: first set req bit after the pointer, modulo N.
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_sel = PW'(idx);
      end
    end
  end

  // Granting when the incremented gap count reaches IDLE_GAP yields exactly
  // IDLE_GAP K words between a tail and the next header.
  assign gap_ok   = (gap_q >= 4'(IDLE_GAP - 1));
  assign src_word = src_data[16*win_q +: 16];

  // Next-state, framing datapath and registered-output values.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    ctrl_d   = 2'b00;
    gnt_d    = gnt_q;
    src_rd_d = '0;
    done_d   = '0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    opc_d    = opc_q;
    len_d    = len_q;
    rem_d    = rem_q;
    csum_d   = csum_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = K_IDLE;
        ctrl_d = 2'b01;
        gap_d  = (gap_q == 4'(IDLE_GAP)) ? gap_q : gap_q + 4'd1;
        if (gap_ok && link_en && found) begin
          state_d        = S_HDR0;
          tx_d           = 16'h2410;
          ctrl_d         = 2'b00;
          gnt_d          = '0;
          gnt_d[win_sel] = 1'b1;
          busy_d         = 1'b1;
          ptr_d          = win_sel;
          win_d          = win_sel;
          opc_d          = opcode[16*win_sel +: 16];
          len_d          = len[8*win_sel +: 8];
          csum_d         = opcode[16*win_sel +: 16];
        end
      end
      S_HDR0: begin
        tx_d    = 16'h1984;
        state_d = S_HDR1;
      end
      S_HDR1: begin
        tx_d     = opc_q;
        rem_d    = len_q;
        src_rd_d = (len_q != 8'd0) ? gnt_q : '0;
        state_d  = S_OPC;
      end
      S_OPC, S_PAY: begin
        if (src_rd_q != '0) begin
          tx_d     = src_word;
          csum_d   = csum_q + src_word;
          rem_d    = rem_q - 8'd1;
          src_rd_d = (rem_q != 8'd1) ? gnt_q : '0;
          state_d  = S_PAY;
        end else begin
          tx_d    = csum_q;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        tx_d    = 16'hDBEF;
        state_d = S_TAIL0;
      end
      S_TAIL0: begin
        tx_d    = 16'hE67B;
        done_d  = gnt_q;
        cnt_d   = cnt_q + 16'd1;
        state_d = S_TAIL1;
      end
      S_TAIL1: begin
        tx_d    = K_IDLE;
        ctrl_d  = 2'b01;
        gnt_d   = '0;
        busy_d  = 1'b0;
        gap_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        tx_d    = K_IDLE;
        ctrl_d  = 2'b01;
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tx_q     <= K_IDLE;
      ctrl_q   <= 2'b01;
      gnt_q    <= '0;
      src_rd_q <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= 16'd0;
      gap_q    <= 4'd0;
      ptr_q    <= PW'(N - 1);
      win_q    <= '0;
      opc_q    <= 16'd0;
      len_q    <= 8'd0;
      rem_q    <= 8'd0;
      csum_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      ctrl_q   <= ctrl_d;
      gnt_q    <= gnt_d;
      src_rd_q <= src_rd_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      opc_q    <= opc_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      csum_q   <= csum_d;
    end
  end

  assign TX_DATA   = tx_q;
  assign TXCTRL    = ctrl_q;
  assign gnt       = gnt_q;
  assign src_rd    = src_rd_q;
  assign frm_done  = done_q;
  assign busy      = busy_q;
  assign frm_cnt   = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gtx_tx_frame_arbiter.sv
// Bench for gtx_tx_frame_arbiter: directed frames, a scoreboard of expected
// link words, grants and frame completions, and a negedge monitor.
module tb_gtx_tx_frame_arbiter;

  localparam int N = 3;
  localparam int G = 4;

  logic            clk;
  logic            rst;
  logic            link_en;
  logic [N-1:0]    req;
  logic [16*N-1:0] opcode;
  logic [8*N-1:0]  len;
  logic [16*N-1:0] src_data;
  logic [N-1:0]    src_rd;
  logic [N-1:0]    gnt;
  logic [N-1:0]    frm_done;
  logic [15:0]     TX_DATA;
  logic [1:0]      TXCTRL;
  logic            busy;
  logic [15:0]     frm_cnt;
  logic [2:0]      dbg_state;

  gtx_tx_frame_arbiter #(.N(N), .IDLE_GAP(G)) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .req(req), .opcode(opcode),
    .len(len), .src_data(src_data), .src_rd(src_rd), .gnt(gnt),
    .frm_done(frm_done), .TX_DATA(TX_DATA), .TXCTRL(TXCTRL), .busy(busy),
    .frm_cnt(frm_cnt), .dbg_state(dbg_state)
  );

  // Clock and counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source model: payload tables, word index advances after each read strobe
  logic [15:0] pay [N][8];
  logic [2:0]  sidx [N];

  always_comb begin
    for (int i = 0; i < N; i++) src_data[16*i +: 16] = pay[i][sidx[i]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || frm_done[i]) sidx[i] <= 3'd0;
      else if (src_rd[i])     sidx[i] <= sidx[i] + 3'd1;
    end
  end

  // Scoreboard queues
  logic [17:0] exp_q[$];       // {TXCTRL, TX_DATA} while busy
  int          gnt_exp_q[$];   // requester expected at each grant
  int          rd_exp_q[$];    // read strobes expected per completed frame
  int          done_req_q[$];  // requester expected at each frm_done
  logic [15:0] done_cnt_q[$];  // frm_cnt expected at each frm_done
  int          gap_exp_q[$];   // K words expected before a header, -1 = skip

  task automatic exp_frame(input int r, input logic [15:0] opc, input int l,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] csum,
                           input logic [15:0] cnt);
    logic [15:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    gnt_exp_q.push_back(r);
    exp_q.push_back({2'b00, 16'h2410});
    exp_q.push_back({2'b00, 16'h1984});
    exp_q.push_back({2'b00, opc});
    for (int k = 0; k < l; k++) exp_q.push_back({2'b00, w[k]});
    exp_q.push_back({2'b00, csum});
    exp_q.push_back({2'b00, 16'hDBEF});
    exp_q.push_back({2'b00, 16'hE67B});
    rd_exp_q.push_back(l);
    done_req_q.push_back(r);
    done_cnt_q.push_back(cnt);
  endtask

  // Monitor: pops expectations whenever the DUT presents a frame event
  logic        mon_en = 1'b0;
  logic [N-1:0] prev_gnt = '0;
  logic        prev_busy = 1'b0;
  int          rd_cnt = 0;
  int          k_run = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt != '0 && prev_gnt == '0) begin
        rd_cnt = 0;
        if (gnt_exp_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
        else chk("gnt_onehot", 32'(gnt), 32'(1) << gnt_exp_q.pop_front());
      end
      if (src_rd != '0) begin
        if (src_rd == gnt) rd_cnt++;
        else rd_cnt += 100;
      end
      if (busy) begin
        if (!prev_busy && gap_exp_q.size() != 0) begin
          int g;
          g = gap_exp_q.pop_front();
          if (g >= 0) chk("idle_gap", 32'(k_run), 32'(g));
        end
        k_run = 0;
        if (exp_q.size() == 0) chk("stream_unexpected", {14'd0, TXCTRL, TX_DATA}, 32'h0);
        else chk("stream", {14'd0, TXCTRL, TX_DATA}, {14'd0, exp_q.pop_front()});
      end else begin
        k_run++;
        chk("idle_k", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b01, 16'h02BC});
      end
      if (frm_done != '0) begin
        if (done_req_q.size() == 0) chk("done_unexpected", 32'(frm_done), 32'h0);
        else begin
          chk("done_bit", 32'(frm_done), 32'(1) << done_req_q.pop_front());
          chk("done_word", 32'(TX_DATA), 32'h0000E67B);
          chk("frm_cnt", 32'(frm_cnt), 32'(done_cnt_q.pop_front()));
          chk("rd_count", 32'(rd_cnt), 32'(rd_exp_q.pop_front()));
        end
      end
    end
    prev_gnt  = gnt;
    prev_busy = busy;
  end

  // Driver tasks
  task automatic set_src(input int r, input logic [15:0] opc, input logic [7:0] l,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2);
    opcode[16*r +: 16] = opc;
    len[8*r +: 8]      = l;
    pay[r][0] = w0; pay[r][1] = w1; pay[r][2] = w2;
  endtask

  task automatic wait_gnt(input int r);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (gnt[r]) begin ok = 1'b1; break; end
    end
    chk("gnt_timeout", 32'(ok), 32'h1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && gnt_exp_q.size() == 0 && done_req_q.size() == 0 && !busy) begin
        ok = 1'b1; break;
      end
    end
    chk("drain_timeout", 32'(ok), 32'h1);
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; link_en = 1'b1; req = '0; opcode = '0; len = '0;
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) pay[i][k] = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tx", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b01, 16'h02BC});
    chk("rst_gnt", {gnt, src_rd, frm_done, busy}, 0);
    chk("rst_frm_cnt", 32'(frm_cnt), 32'h0);
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Single frame, three payload words
    set_src(0, 16'h0001, 8'd3, 16'h0002, 16'h0003, 16'h0004);
    exp_frame(0, 16'h0001, 3, 16'h0002, 16'h0003, 16'h0004, 16'h000A, 16'd1);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_drain();

    // Zero-length frame: checksum equals the opcode, no reads
    set_src(2, 16'hA5A5, 8'd0, 16'h0, 16'h0, 16'h0);
    exp_frame(2, 16'hA5A5, 0, 16'h0, 16'h0, 16'h0, 16'hA5A5, 16'd2);
    req[2] = 1'b1;
    wait_gnt(2);
    req[2] = 1'b0;
    wait_drain();

    // All three requesting: round-robin 0,1,2,0 with IDLE_GAP K words between
    set_src(0, 16'h1000, 8'd1, 16'h0011, 16'h0, 16'h0);
    set_src(1, 16'h2000, 8'd1, 16'h0022, 16'h0, 16'h0);
    set_src(2, 16'h3000, 8'd1, 16'h0033, 16'h0, 16'h0);
    gap_exp_q.push_back(-1);
    gap_exp_q.push_back(G);
    gap_exp_q.push_back(G);
    gap_exp_q.push_back(G);
    exp_frame(0, 16'h1000, 1, 16'h0011, 16'h0, 16'h0, 16'h1011, 16'd3);
    exp_frame(1, 16'h2000, 1, 16'h0022, 16'h0, 16'h0, 16'h2022, 16'd4);
    exp_frame(2, 16'h3000, 1, 16'h0033, 16'h0, 16'h0, 16'h3033, 16'd5);
    exp_frame(0, 16'h1000, 1, 16'h0011, 16'h0, 16'h0, 16'h1011, 16'd6);
    req = 3'b111;
    begin
      int rises;
      logic [N-1:0] pg;
      rises = 0;
      pg = '0;
      for (int c = 0; c < 300 && rises < 4; c++) begin
        @(posedge clk); #1;
        if (gnt != '0 && pg == '0) rises++;
        pg = gnt;
      end
      chk("rr_grants", 32'(rises), 32'd4);
    end
    req = '0;
    wait_drain();

    // Checksum wraps; opcode/len changes after the grant are ignored
    set_src(1, 16'hFFFF, 8'd1, 16'h0002, 16'h0, 16'h0);
    exp_frame(1, 16'hFFFF, 1, 16'h0002, 16'h0, 16'h0, 16'h0001, 16'd7);
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    opcode[31:16] = 16'hDEAD;
    len[15:8] = 8'd9;
    wait_drain();

    // link_en low holds off grants; dropping it mid-frame does not truncate
    link_en = 1'b0;
    set_src(1, 16'h5A00, 8'd2, 16'h0100, 16'h0200, 16'h0);
    req[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("link_gate_busy", 32'(busy), 32'h0);
    exp_frame(1, 16'h5A00, 2, 16'h0100, 16'h0200, 16'h0, 16'h5D00, 16'd8);
    link_en = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    link_en = 1'b0;
    wait_drain();
    link_en = 1'b1;

    // Reset during the second payload word of a len-5 frame
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst2_frm_cnt", 32'(frm_cnt), 32'h0);
    opcode[15:0] = 16'h7700;
    len[7:0] = 8'd5;
    for (int k = 0; k < 5; k++) pay[0][k] = 16'(k + 1);
    gnt_exp_q.push_back(0);
    exp_q.push_back({2'b00, 16'h2410});
    exp_q.push_back({2'b00, 16'h1984});
    exp_q.push_back({2'b00, 16'h7700});
    exp_q.push_back({2'b00, 16'h0001});
    exp_q.push_back({2'b00, 16'h0002});
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_pre_word", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b00, 16'h0002});
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_tx", {14'd0, TXCTRL, TX_DATA}, {14'd0, 2'b01, 16'h02BC});
    chk("abort_gnt_rd", {gnt, src_rd, frm_done}, 0);
    chk("abort_frm_cnt", 32'(frm_cnt), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_left", 32'(exp_q.size() + gnt_exp_q.size() + done_req_q.size()), 32'h0);
    chk("abort_no_done", 32'(frm_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gtx_tx_frame_arbiter.md
Name: gtx_tx_frame_arbiter

Overview:
- Shares the single 16-bit GTX TX lane between N requesters (command acknowledge, spot data, star-image telemetry).
- Arbitrates round-robin and frames each granted transfer with the link protocol: K-idle 0x02BC, header 0x2410/0x1984, opcode, payload, checksum, tail 0xDBEF/0xE67B.
- Pulls payload words from the granted source and emits K-idle between frames.
- Its output is the transmit-side counterpart of the command receive parser on the same link.

Parameters:
- N, 3, number of requesters (2..8).
- IDLE_GAP, 4, minimum count of K-idle words between the last tail word and the next header (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. One clock domain; no other reset.
- link_en  in  1  1 = new grants allowed; 0 = finish the current frame, then idle.
- req  in  N  per-requester frame request, level; held until the matching gnt bit rises.
- opcode  in  16*N  per-requester opcode word; slice i = bits [16i+15:16i].
- len  in  8*N  per-requester payload length in words, 0..255.
- src_data  in  16*N  per-requester payload word, valid whenever src_rd[i] is high.
- src_rd  out  N  one-cycle read strobe; the source advances to its next word on the following cycle.
- gnt  out  N  one-hot grant, high for the whole framed transfer.
- frm_done  out  N  one-cycle pulse when requester i's frame completes.
- TX_DATA  out  16  GTX transmit data, registered.
- TXCTRL  out  2  00 = data, 01 = K-char 0x02BC, registered.
- busy  out  1  high from header through tail.
- frm_cnt  out  16  count of completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset values:
  - TX_DATA = 0x02BC, TXCTRL = 01.
  - gnt, src_rd, frm_done, busy = 0; frm_cnt = 0.
  - gap_cnt = 0; round-robin pointer = N-1, so requester 0 wins first.
- States:
  - IDLE -> HDR0 -> HDR1 -> OPC -> PAY (skipped when len = 0) -> CSUM -> TAIL0 -> TAIL1 -> IDLE.
- IDLE:
  - Emits 0x02BC/01 every cycle.
  - gap_cnt increments, saturating at IDLE_GAP.
- Grant cycle G:
  - Conditions: IDLE, gap_cnt >= IDLE_GAP, link_en = 1, |req != 0.
  - Winner is the first set req bit searching from pointer+1, modulo N; pointer <= winner.
  - opcode[winner] and len[winner] (L) are latched at G; later changes have no effect.
  - req bits dropped before G are ignored; req is sampled only in grant cycles.
- Registered output timeline relative to G:
  - G+1: 0x2410/00. gnt and busy rise.
  - G+2: 0x1984/00.
  - G+3: opcode/00.
  - G+4 .. G+3+L: payload words.
  - G+4+L: checksum/00.
  - G+5+L: 0xDBEF/00.
  - G+6+L: 0xE67B/00. frm_done pulse, frm_cnt++.
  - G+7+L: 0x02BC/01. gnt and busy fall; gap_cnt restarts at 0.
- src_rd[winner] is high in cycles G+3 .. G+2+L (L cycles; none when L = 0).
  - src_data sampled in cycle c appears on TX_DATA at c+1.
- Checksum:
  - 16-bit sum, modulo 2^16 (carry discarded), of the opcode and all L payload words.
  - Header, tail and K words are excluded.
- Back-to-back frames:
  - The earliest next grant is the cycle in which gap_cnt reaches IDLE_GAP.
  - This guarantees exactly IDLE_GAP K words between frames when requests are pending.
- link_en:
  - Sampled only in IDLE; deasserting it mid-frame does not truncate the frame.
- Simultaneous requests:
  - Each requester is served once per round-robin cycle.
  - A requester that keeps req high waits at most N-1 frames.
- Reset asserted mid-frame:
  - Next cycle output is 0x02BC/01; gnt and src_rd drop.
  - No frm_done pulse, frm_cnt is unchanged, and the partial frame is abandoned.
  - Sources must flush on gnt falling without frm_done.
- frm_done and gnt are never asserted for more than one requester at a time.

Test Plan:
- Reset, no requests, 20 cycles -> TX_DATA = 0x02BC, TXCTRL = 01 every cycle; gnt = 0, frm_cnt = 0.
- req[0] with opcode 0x0001, len 3, data 0x0002/0x0003/0x0004:
  - Required stream: K, 2410, 1984, 0001, 0002, 0003, 0004, 000A, DBEF, E67B, K.
  - src_rd[0] high for exactly 3 cycles; frm_done[0] pulses on E67B; frm_cnt = 1.
- req[2] with len 0, opcode 0xA5A5 -> stream 2410, 1984, A5A5, A5A5, DBEF, E67B; src_rd stays 0.
- req = 3'b111 held, all len 1 -> grant order 0, 1, 2, 0; exactly IDLE_GAP = 4 K words between each tail and the next header.
- Checksum wrap: opcode 0xFFFF, payload 0x0002 -> checksum 0x0001.
- Abort and gating:
  - rst pulsed at the second payload word of a len-5 frame -> next word 0x02BC/01; no frm_done; frm_cnt unchanged.
  - link_en = 0 with req pending -> no header emitted until link_en = 1.
